// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader.
// Holds the default RAM geometry and the loader FSM state encoding.
package prog_loader_pkg;

  localparam int ADDR_W_DEF = 5;  // instruction RAM depth 2**5 = 32 words
  localparam int DATA_W_DEF = 9;  // matches processor DIN/BusWires width

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/prog_loader_ram.sv
// Instruction RAM for the program loader.
// One synchronous write port and one registered read port. The read is
// read-first: on a same-address read and write, the old word is returned.
// Storage is not reset. Only the read register is reset.
// Ports:
//   Clock, Resetn      - clock, async active-low reset (read register only)
//   we, waddr, wdata   - write port
//   raddr, rdata       - registered read port (1-cycle latency)
module prog_loader_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 9
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge Clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Reads the pre-write contents, which gives read-first behaviour.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) rdata <= '0;
    else         rdata <= mem[raddr];
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader. Fills the instruction RAM from a valid/ready word stream
// and holds the processor in reset until a load session completes.
// Ports:
//   Clock, Resetn          - clock, async active-low reset
//   Load, Length           - start a session of Length words (0 = full RAM)
//   Abort                  - drop the active session
//   WrValid/WrData/WrReady - word stream into the RAM
//   RdAddr/RdData          - processor fetch port (registered, read-first)
//   Busy, LoadDone         - session status, completion pulse
//   CpuResetn              - processor hold-in-reset (low until a load completes)
//   WordCount              - words accepted in the current/most recent session
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Load,
  input  logic [ADDR_W-1:0] Length,
  input  logic              Abort,
  input  logic              WrValid,
  input  logic [DATA_W-1:0] WrData,
  output logic              WrReady,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [DATA_W-1:0] RdData,
  output logic              Busy,
  output logic              LoadDone,
  output logic              CpuResetn,
  output logic [ADDR_W:0]   WordCount
);

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] count_inc;
  logic            we;

  // The session never exceeds the RAM depth. The low bits of WordCount
  // therefore serve as the write pointer, with no wrap.
  assign count_inc = WordCount + ONE;
  assign we        = WrReady & WrValid & ~Abort;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= S_IDLE;
      len_q     <= '0;
      WordCount <= '0;
      WrReady   <= 1'b0;
      Busy      <= 1'b0;
      LoadDone  <= 1'b0;
      CpuResetn <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (Load) begin
          state     <= S_LOAD;
          WordCount <= '0;
          len_q     <= (Length == '0) ? FULL : {1'b0, Length};
          WrReady   <= 1'b1;
          Busy      <= 1'b1;
          CpuResetn <= 1'b0;
        end
        S_LOAD: begin
          if (Abort) begin
            // CpuResetn is already low and stays low until a later completion.
            state   <= S_IDLE;
            WrReady <= 1'b0;
            Busy    <= 1'b0;
          end else if (WrValid) begin
            WordCount <= count_inc;
            if (count_inc == len_q) begin
              state    <= S_FINISH;
              WrReady  <= 1'b0;
              LoadDone <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          state     <= S_IDLE;
          LoadDone  <= 1'b0;
          Busy      <= 1'b0;
          CpuResetn <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          WrReady <= 1'b0;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

  prog_loader_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) inst_ram (
    .Clock (Clock),
    .Resetn(Resetn),
    .we    (we),
    .waddr (WordCount[ADDR_W-1:0]),
    .wdata (WrData),
    .raddr (RdAddr),
    .rdata (RdData)
  );

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  localparam int AW = 5, DW = 9, DEPTH = 32;

  logic          Clock = 1'b0, Resetn = 1'b0, Load = 1'b0, Abort = 1'b0, WrValid = 1'b0;
  logic [AW-1:0] Length = '0, RdAddr = '0;
  logic [DW-1:0] WrData = '0;
  logic          WrReady, Busy, LoadDone, CpuResetn;
  logic [DW-1:0] RdData;
  logic [AW:0]   WordCount;

  int checks = 0, failures = 0;

  // Reference RAM image: contents written so far, plus a known flag per word.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            known   [DEPTH];
  logic [DW-1:0] dq      [DEPTH];  // data for the next session

  prog_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock(Clock), .Resetn(Resetn), .Load(Load), .Length(Length), .Abort(Abort),
    .WrValid(WrValid), .WrData(WrData), .WrReady(WrReady), .RdAddr(RdAddr),
    .RdData(RdData), .Busy(Busy), .LoadDone(LoadDone), .CpuResetn(CpuResetn),
    .WordCount(WordCount)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock); #1;
  endtask

  // Status vector {Busy, WrReady, LoadDone, CpuResetn}.
  function automatic logic [3:0] st();
    return {Busy, WrReady, LoadDone, CpuResetn};
  endfunction

  // Drive one session. gap: 0 = valid every cycle, 1 = every other cycle,
  // 2 = random. abort_at >= 0 aborts once that many words are accepted.
  task automatic run_session(input int len, input int gap, input int abort_at,
                             input bit noise, input string tag);
    int acc = 0, cyc = 0;
    bit v, ab, done = 0;
    Load = 1; Length = AW'(len); tick; Load = 0; Length = AW'($urandom);
    checks++;
    if (st() !== 4'b1100 || WordCount !== '0) begin
      failures++;
      $display("FAIL %s start: status=%b count=%0d want status=1100 count=0", tag, st(), WordCount);
    end
    while (!done) begin
      if (cyc > 300) begin
        checks++; failures++;
        $display("FAIL %s timeout: acc=%0d want %0d", tag, acc, len);
        break;
      end
      v = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      ab = (abort_at >= 0 && acc == abort_at);
      WrValid = v; WrData = v ? dq[acc] : DW'($urandom); Abort = ab;
      if (noise) Load = 1'($urandom_range(0, 1));
      checks++;
      if (WrReady !== 1'b1) begin
        failures++;
        $display("FAIL %s ready: WrReady=%b want 1 (acc=%0d)", tag, WrReady, acc);
      end
      tick; cyc++;
      if (ab) begin
        Abort = 0; WrValid = 0; Load = 0;
        checks++;
        if (st() !== 4'b0000 || WordCount !== (AW+1)'(acc)) begin
          failures++;
          $display("FAIL %s abort: status=%b count=%0d want status=0000 count=%0d", tag, st(), WordCount, acc);
        end
        tick;
        checks++;
        if (CpuResetn !== 1'b0 || Busy !== 1'b0 || LoadDone !== 1'b0) begin
          failures++;
          $display("FAIL %s post_abort: status=%b want 0000", tag, st());
        end
        done = 1;
      end else begin
        if (v) begin ref_mem[acc] = dq[acc]; known[acc] = 1; acc++; end
        checks++;
        if (WordCount !== (AW+1)'(acc)) begin
          failures++;
          $display("FAIL %s count: WordCount=%0d want %0d", tag, WordCount, acc);
        end
        if (acc == len) begin
          checks++;
          if (st() !== 4'b1010) begin
            failures++;
            $display("FAIL %s finish: status=%b want 1010", tag, st());
          end
          // Offered words and Load/Abort in the completion cycle must be ignored.
          WrValid = 1; WrData = DW'($urandom);
          if (noise) begin Load = 1'($urandom_range(0, 1)); Abort = 1'($urandom_range(0, 1)); end
          tick; Load = 0; Abort = 0; WrValid = 0;
          checks++;
          if (st() !== 4'b0001 || WordCount !== (AW+1)'(len)) begin
            failures++;
            $display("FAIL %s done: status=%b count=%0d want status=0001 count=%0d", tag, st(), WordCount, len);
          end
          done = 1;
        end else begin
          checks++;
          if (st() !== 4'b1100) begin
            failures++;
            $display("FAIL %s mid: status=%b want 1100", tag, st());
          end
        end
      end
    end
    WrValid = 0; Load = 0; Abort = 0;
  endtask

  task automatic readback(input int a, input string tag);
    RdAddr = AW'(a); tick;
    if (known[a]) begin
      checks++;
      if (RdData !== ref_mem[a]) begin
        failures++;
        $display("FAIL %s read[%0d]: RdData=%h want %h", tag, a, RdData, ref_mem[a]);
      end
    end
  endtask

  task automatic test_reset;
    tick; tick;
    checks++;
    if (st() !== 4'b0000 || WordCount !== '0 || RdData !== '0) begin
      failures++;
      $display("FAIL reset_hold: status=%b count=%0d rd=%h want all 0", st(), WordCount, RdData);
    end
    Resetn = 1; tick;
    checks++;
    if (st() !== 4'b0000 || WordCount !== '0) begin
      failures++;
      $display("FAIL reset_idle: status=%b count=%0d want 0", st(), WordCount);
    end
  endtask

  task automatic test_basic;
    dq[0] = 9'h101; dq[1] = 9'h0A5; dq[2] = 9'h1FF;
    run_session(3, 0, -1, 0, "basic");
    for (int i = 0; i < 3; i++) readback(i, "basic");
  endtask

  task automatic test_full;
    for (int i = 0; i < DEPTH; i++) dq[i] = DW'(i);
    run_session(32, 0, -1, 0, "full");
    readback(31, "full"); readback(0, "full"); readback(17, "full");
  endtask

  task automatic test_gapped;
    for (int i = 0; i < DEPTH; i++) dq[i] = DW'($urandom);
    run_session(4, 1, -1, 0, "gapped");
    // Words offered while idle must not land in the RAM.
    WrValid = 1;
    for (int i = 0; i < 3; i++) begin WrData = DW'($urandom); tick; end
    WrValid = 0;
    for (int i = 0; i < 6; i++) readback(i, "gapped");
  endtask

  task automatic test_abort;
    for (int i = 0; i < DEPTH; i++) dq[i] = DW'($urandom);
    run_session(5, 0, 2, 0, "abort");
    for (int i = 0; i < 4; i++) readback(i, "abort");
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < DEPTH; i++) dq[i] = DW'($urandom);
    Load = 1; Length = AW'(6); tick; Load = 0;
    WrValid = 1;
    for (int i = 0; i < 2; i++) begin
      WrData = dq[i]; tick; ref_mem[i] = dq[i]; known[i] = 1;
    end
    WrValid = 0;
    Resetn = 0; #1;
    checks++;
    if (st() !== 4'b0000 || WordCount !== '0 || RdData !== '0) begin
      failures++;
      $display("FAIL reset_mid: status=%b count=%0d rd=%h want all 0", st(), WordCount, RdData);
    end
    #2 Resetn = 1;
    tick;
    checks++;
    if (st() !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_idle: status=%b want 0000", st());
    end
    dq[0] = DW'($urandom);
    run_session(1, 0, -1, 0, "after_reset");
    readback(0, "after_reset"); readback(1, "after_reset");
  endtask

  task automatic test_read_first;
    for (int i = 0; i < 8; i++) dq[i] = DW'($urandom);
    dq[7] = 9'h0AA;
    run_session(8, 0, -1, 0, "rf_prep");
    Load = 1; Length = AW'(8); tick; Load = 0;
    RdAddr = AW'(7); WrValid = 1;
    for (int i = 0; i < 7; i++) begin
      WrData = DW'($urandom); ref_mem[i] = WrData; tick;
    end
    WrData = 9'h155; tick; WrValid = 0;
    ref_mem[7] = 9'h155;
    checks++;
    if (RdData !== 9'h0AA || LoadDone !== 1'b1) begin
      failures++;
      $display("FAIL read_first_old: RdData=%h LoadDone=%b want 0aa 1", RdData, LoadDone);
    end
    tick;
    checks++;
    if (RdData !== 9'h155) begin
      failures++;
      $display("FAIL read_first_new: RdData=%h want 155", RdData);
    end
  endtask

  task automatic test_random;
    for (int s = 0; s < 6; s++) begin
      int len, ab;
      len = $urandom_range(1, 32);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      for (int i = 0; i < DEPTH; i++) dq[i] = DW'($urandom);
      run_session(len, 2, ab, 1, "random");
      for (int k = 0; k < 4; k++) readback($urandom_range(0, DEPTH - 1), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; known[i] = 0; end
    test_reset;
    test_basic;
    test_full;
    test_gapped;
    test_abort;
    test_reset_mid;
    test_read_first;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning instruction RAM address width (depth 2**ADDR_W = 32 words).
REQ-002 SHALL have parameter DATA_W, default 9, meaning instruction word width, equal to the processor DIN/BusWires width.
REQ-003 SHALL have port Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port Resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Load  input  1  level sampled in IDLE; starts a load session.
REQ-006 SHALL have port Length  input  ADDR_W  word count for the session, sampled with Load; 0 means 2**ADDR_W words.
REQ-007 SHALL have port Abort  input  1  terminates an active session without completion.
REQ-008 SHALL have port WrValid  input  1  producer offers WrData.
REQ-009 SHALL have port WrData  input  DATA_W  instruction word to store.
REQ-010 SHALL have port WrReady  output  1  loader accepts WrData this cycle.
REQ-011 SHALL have port RdAddr  input  ADDR_W  processor-side fetch address.
REQ-012 SHALL have port RdData  output  DATA_W  word at RdAddr, registered.
REQ-013 SHALL have port Busy  output  1  high while a session is in LOAD or FINISH.
REQ-014 SHALL have port LoadDone  output  1  one-cycle pulse on session completion.
REQ-015 SHALL have port CpuResetn  output  1  active-low hold-in-reset for the processor.
REQ-016 SHALL have port WordCount  output  ADDR_W+1  words accepted in the current or most recent session.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, FINISH.
REQ-018 In IDLE, Load=1 SHALL move to LOAD next cycle, clear the write pointer and WordCount, and latch Length (0 latched as 2**ADDR_W).
REQ-019 WrReady SHALL be 1 exactly in LOAD and 0 in IDLE and FINISH.
REQ-020 A transfer SHALL occur on a cycle with WrValid=1 and WrReady=1: WrData is written at the write pointer; the pointer and WordCount each increment by 1.
REQ-021 The write pointer SHALL never wrap within a session; the transfer bringing WordCount to the latched length SHALL move the FSM to FINISH.
REQ-022 FINISH SHALL last exactly one cycle, assert LoadDone in that cycle, then return to IDLE.
REQ-023 Load asserted in LOAD or FINISH SHALL be ignored.
REQ-024 Abort=1 in LOAD SHALL return to IDLE next cycle: no LoadDone, no write on that cycle even if WrValid=1; already-written words stay in RAM.
REQ-025 Abort in IDLE or FINISH SHALL have no effect.
REQ-026 RdData SHALL equal RAM[RdAddr] sampled at the previous rising edge (1-cycle latency).
REQ-027 On a same-cycle read and write of the same address, RdData SHALL return the old word (read-first).
REQ-028 CpuResetn SHALL be registered, low in LOAD and FINISH, and rise on the first IDLE cycle after a LoadDone.
REQ-029 After an Abort, CpuResetn SHALL stay low until a later session completes.
REQ-030 Busy SHALL be 1 in LOAD and FINISH and 0 in IDLE.

Reset
REQ-031 Resetn=0 SHALL asynchronously force: state IDLE, write pointer 0, WordCount 0, WrReady 0, Busy 0, LoadDone 0, CpuResetn 0, RdData 0.
REQ-032 Reset SHALL NOT clear RAM contents; RAM content is undefined until written.
REQ-033 Reset asserted mid-session SHALL discard the session with no LoadDone.

Structure
REQ-034 A shared package SHALL hold ADDR_W and DATA_W defaults and the FSM state enumeration.
REQ-035 The RAM SHALL be a sub-module inst_ram: single clock, one write port, one registered read port, read-first, no reset on its storage.
REQ-036 The FSM, pointer, counter and CpuResetn logic SHALL reside in prog_loader.

Verification
REQ-037 Reset, Load=1, Length=3, words 0x101, 0x0A5, 0x1FF with WrValid held high -> WrReady high for 3 cycles, LoadDone one cycle after the 3rd transfer, CpuResetn rises the following cycle, and RdAddr=0..2 read back 0x101, 0x0A5, 0x1FF.
REQ-038 Length=0 with 32 words, data = address -> WordCount=32 and LoadDone; RdAddr=31 returns 0x01F.
REQ-039 Length=4 with WrValid gapped (high every other cycle) -> exactly 4 writes, no extra writes, LoadDone after the 4th accepted word.
REQ-040 Abort after 2 of 5 words -> Busy falls, no LoadDone, CpuResetn stays 0, WordCount=2; addresses 0..1 hold the new data.
REQ-041 Resetn pulsed low mid-session -> all outputs immediately at reset values; a new Load=1, Length=1 session then completes normally.
REQ-042 Write 0x155 to address 7 while RdAddr=7 and the old word is 0x0AA -> next RdData 0x0AA, following cycle 0x155.
